gray_stream_checker: RTL
========================

// Module: gray_stream_checker
// PURPOSE
//   Downstream consumer of the 8-bit Gray counter stage. Samples the Gray code and its
//   zero-marker each valid cycle, decodes Gray to binary, and checks the stream.
//   Checks: every step is +1 (mod 2^CBITS) or a hold. Marker and value must agree.
//   Counts wrap-arounds and raises a sticky, coded error for the monitor/assertion layer.
// PARAMETERS
//   CBITS  8   width of Gray input / binary output
//   WBITS  16  width of wrap counter (saturating)
// PORTS
//   clk       in   1      rising-edge clock; single clock domain
//   rst       in   1      asynchronous, active-low reset (asserted when 0)
//   gray_in   in   CBITS  Gray-coded count from upstream counter
//   gray_vld  in   1      gray_in/sig_in valid this cycle
//   sig_in    in   1      upstream "count==0" marker, qualified by gray_vld
//   clr_err   in   1      one-cycle pulse: clear error, return to acquire
//   bin_out   out  CBITS  decoded binary value of last accepted sample
//   bin_vld   out  1      pulses 1 cycle after each accepted gray_vld
//   locked    out  1      1 while in TRACK state
//   wrap_cnt  out  WBITS  number of observed wraps (all-ones -> 0); saturates at all-ones
//   err       out  1      sticky error flag (1 in ERR state)
//   err_code  out  2      00 none, 01 multi-bit Gray change, 10 single-bit non-increment, 11 marker mismatch
// BEHAVIOUR
//   Reset (rst=0, async): state=ACQ; bin_out=0, bin_vld=0, locked=0, wrap_cnt=0, err=0,
//     err_code=00, internal prev_gray=0, prev_bin=0. Deassertion takes effect at next clk edge.
//   Decode: b[CBITS-1]=g[CBITS-1]; b[i]=b[i+1]^g[i]. Combinational, then registered.
//   Latency: gray_vld in cycle N -> bin_out/bin_vld valid in cycle N+1 (1 cycle). bin_vld also pulses in ERR.
//   The sample is "accepted" when gray_vld=1 and clr_err=0; bin_out holds between samples.
//   FSM states ACQ, TRACK, ERR:
//   - ACQ: first accepted sample loads prev_gray/prev_bin, no step check; -> TRACK.
//     Marker check still applies: sig_in=1 with decoded value !=0 -> ERR, code 11.
//   - TRACK: each accepted sample with new decoded value d:
//       d==prev_bin                  : hold, OK, stay
//       d==prev_bin+1 (mod 2^CBITS)  : OK, stay; if prev_bin=all-ones and d=0, wrap_cnt+1 (saturating)
//       popcount(gray_in^prev_gray)>1: -> ERR, code 01
//       else (1-bit change, wrong step): -> ERR, code 10
//       then, if still OK and sig_in != (d==0): -> ERR, code 11
//       precedence when several apply: 01 > 10 > 11
//     prev_gray/prev_bin update on every accepted sample, including the erroring one.
//   - ERR: err=1, err_code frozen at first error, wrap_cnt frozen; samples still decoded to bin_out.
//   clr_err=1 (any state): next state ACQ, err=0, err_code=00; wrap_cnt kept; the same-cycle
//     sample is ignored (clr_err wins, no bin_vld).
//   locked = (state==TRACK), registered. wrap_cnt at all-ones stays all-ones.
//   Reset mid-operation: immediate return to reset values regardless of state or pending sample.
//   gray_vld=0: no state change, no checks, bin_vld=0.
// TESTING
//   1. Reset, then feed Gray of 0,1,2..255,0,1 with vld each cycle and sig_in=(bin==0)
//      -> locked=1 from cycle 2 on, bin_out follows input 1 cycle late, wrap_cnt=1, err=0.
//   2. In TRACK, after gray 0x03 (bin 2) send 0x05 (2 bits flip) -> err=1, err_code=01, locked=0.
//   3. After gray 0x02 (bin 3) send 0x03 (bin 2, 1 bit) -> err_code=10; pulse clr_err -> ACQ, err=0, wrap_cnt unchanged.
//   4. Send bin 5 with sig_in=1, then bin 0 with sig_in=0 -> err_code=11 on the first;
//      separately, hold bin 7 three samples -> no error.
//   5. Force wrap_cnt to 16'hFFFF via a long run (or WBITS=2 build, 5 wraps) -> wrap_cnt saturates at max.
//   6. Drop rst mid-stream with gray_vld=1 and clr_err=1 together -> all outputs 0 immediately, state ACQ.
//      Then clr_err+gray_vld same cycle in TRACK -> no bin_vld, state ACQ.

Source files
------------

// File: rtl/gray_stream_checker.sv
// gray_stream_checker
//   Consumes the Gray-coded count and zero-marker from the upstream counter.
//   Each accepted sample is decoded to binary and registered one cycle later.
//   The stream must step by +1 (mod 2^CBITS) or hold. The marker must agree
//   with the decoded value. The first violation latches a sticky error code.
//   Wraps (all-ones -> 0) are counted in a saturating counter.
//
//   Handshake: gray_vld qualifies gray_in and sig_in for one cycle. There is
//   no backpressure. A sample is accepted when gray_vld=1 and clr_err=0.
//   bin_vld pulses for exactly one cycle, on the cycle after each accepted
//   sample. bin_out holds its value between samples.
module gray_stream_checker #(
  parameter int CBITS = 8,
  parameter int WBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             gray_vld,
  input  logic             sig_in,
  input  logic             clr_err,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_vld,
  output logic             locked,
  output logic [WBITS-1:0] wrap_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_MULTI  = 2'b01;
  localparam logic [1:0] CODE_STEP   = 2'b10;
  localparam logic [1:0] CODE_MARKER = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [CBITS-1:0] prev_gray;
  logic [CBITS-1:0] prev_bin;
  logic [CBITS-1:0] dec_bin;
  logic [CBITS-1:0] inc_bin;
  logic [1:0]       chk_code;
  logic             accept;
  logic             is_wrap;

  // Clearing the error takes priority over the sample in the same cycle.
  assign accept  = gray_vld & ~clr_err;
  assign inc_bin = prev_bin + CBITS'(1);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec_bin            = '0;
    dec_bin[CBITS-1]   = gray_in[CBITS-1];
    for (int i = CBITS - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ gray_in[i];
    end
  end

  // Classify the current sample. Precedence is multi-bit, then step, then marker.
  always_comb begin
    chk_code = CODE_NONE;
    if (accept) begin
      case (state)
        ACQ: begin
          if (sig_in && (dec_bin != '0)) chk_code = CODE_MARKER;
        end
        TRACK: begin
          if ((dec_bin == prev_bin) || (dec_bin == inc_bin)) begin
            if (sig_in != (dec_bin == '0)) chk_code = CODE_MARKER;
          end else if ($countones(gray_in ^ prev_gray) > 1) begin
            chk_code = CODE_MULTI;
          end else begin
            chk_code = CODE_STEP;
          end
        end
        default: chk_code = CODE_NONE;
      endcase
    end
  end

  // A wrap counts only on a clean +1 step from all-ones to zero while tracking.
  assign is_wrap = accept && (state == TRACK) && (chk_code == CODE_NONE) &&
                   (prev_bin == '1) && (dec_bin == '0);

  // Next-state logic: clr_err forces acquisition; any check failure goes to ERR.
  always_comb begin
    state_nxt = state;
    if (clr_err) begin
      state_nxt = ACQ;
    end else if (accept) begin
      case (state)
        ACQ:     state_nxt = (chk_code != CODE_NONE) ? ERR : TRACK;
        TRACK:   state_nxt = (chk_code != CODE_NONE) ? ERR : TRACK;
        default: state_nxt = state;
      endcase
    end
  end

  // State, datapath and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACQ;
      bin_out   <= '0;
      bin_vld   <= 1'b0;
      prev_gray <= '0;
      prev_bin  <= '0;
      wrap_cnt  <= '0;
      err_code  <= CODE_NONE;
    end else begin
      state   <= state_nxt;
      bin_vld <= accept;
      if (accept) begin
        bin_out   <= dec_bin;
        prev_gray <= gray_in;
        prev_bin  <= dec_bin;
      end
      if (clr_err) begin
        err_code <= CODE_NONE;
      end else if ((state != ERR) && (chk_code != CODE_NONE)) begin
        err_code <= chk_code;
      end
      if (is_wrap && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + WBITS'(1);
      end
    end
  end

  assign locked    = (state == TRACK);
  assign err       = (state == ERR);
  assign state_dbg = state;

endmodule
